// File: rtl/fifo_uart_tx_pkg.sv
// rtl/fifo_uart_tx_pkg.sv - shared state encodings and parity modes for the FIFO-fed UART transmitter
package fifo_uart_tx_pkg;

  // Transmitter FSM states (3-bit encoding kept stable for legacy users)
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_PARITY = 3'd5;
  localparam logic [2:0] S_STOP   = 3'd6;

  // Parity modes selected by the PARITY parameter
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/fifo_uart_tx_baud_gen.sv
// rtl/fifo_uart_tx_baud_gen.sv - bit-period divider with synchronous restart and one-cycle tick
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt;

  // Count 0..CLKS_PER_BIT-1 and wrap; clear pins the count at 0 so the first bit is full length
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || cnt == LAST_CNT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // Tick marks the last cycle of a bit period; suppressed while held in clear
  assign tick = !clear && (cnt == LAST_CNT);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops one word per frame from a synchronous FIFO and shifts it out as UART
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_re,
  output logic                  tx,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DATA_WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
  localparam logic             ODD_INV   = (PARITY == PAR_ODD);

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] shift_nx;
  logic                  par_bit;
  logic [IDX_W-1:0]      bit_idx;
  logic                  tick;
  logic                  baud_clear;

  assign shift_nx = shift >> 1;

  // Bit timing only runs once the frame starts, so START always gets a full period
  assign baud_clear = (state == S_IDLE) || (state == S_FETCH) || (state == S_LOAD);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (tick)
  );

  // Frame FSM: every output is registered; bit_idx counts data bits, then stop bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      shift   <= '0;
      par_bit <= 1'b0;
      bit_idx <= '0;
      tx      <= 1'b1;
      fifo_re <= 1'b0;
      busy    <= 1'b0;
    end else begin
      fifo_re <= 1'b0;
      case (state)
        S_IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (!fifo_empty) begin
            state   <= S_FETCH;
            fifo_re <= 1'b1;
            busy    <= 1'b1;
          end
        end
        S_FETCH: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          shift   <= fifo_data;
          par_bit <= (^fifo_data) ^ ODD_INV;
          bit_idx <= '0;
          tx      <= 1'b0;
          state   <= S_START;
        end
        S_START: begin
          if (tick) begin
            tx    <= shift[0];
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
              if (PARITY != PAR_NONE) begin
                tx    <= par_bit;
                state <= S_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift   <= shift_nx;
              tx      <= shift_nx[0];
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            tx    <= 1'b1;
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (bit_idx == LAST_STOP) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
